// File: rtl/lm07_spi_reader_if.sv
// lm07_spi_reader_if: SPI wires between the LM07 reader (master) and the sensor (slave)
interface lm07_spi_reader_if;
    logic cs;
    logic sck;
    logic sio;
    modport master (output cs, output sck, input sio);
    modport slave (input cs, input sck, output sio);
endinterface

// File: rtl/lm07_spi_reader.sv
// lm07_spi_reader: periodic SPI read of an LM07/LM70 16-bit frame into registered temperature
// Define LM07_AVG_EN to average each good frame with the previous good frame.
module lm07_spi_reader #(
    parameter int SCK_DIV     = 2,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    lm07_spi_reader_if.master    spi,
    output logic [15:0]          temp_raw,
    output logic [8:0]           temp_int,
    output logic [1:0]           temp_frac,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CMAX = SCK_DIV > IDLE_CYCLES ? SCK_DIV : IDLE_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] DIV_END = CW'(SCK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   raw_q, raw_d;
    logic [10:0]   temp_q, temp_d;
    logic          cs_q, cs_d, sck_q, sck_d;
    logic          valid_q, valid_d, err_q, err_d, busy_q, busy_d;
    logic          good;
`ifdef LM07_AVG_EN
    logic [10:0]        hist_q, hist_d;
    logic               have_q, have_d;
    logic signed [11:0] sum;
    assign sum = $signed({shift_q[15], shift_q[15:5]}) + $signed({hist_q[10], hist_q});
`endif

    assign good = shift_q[4:0] == 5'h1f;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        sck_d   = sck_q;
        raw_d   = raw_q;
        temp_d  = temp_q;
        err_d   = err_q;
`ifdef LM07_AVG_EN
        hist_d  = hist_q;
        have_d  = have_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ena) state_d = SETUP;
            end
            SETUP: if (cnt_q == DIV_END) begin
                state_d = SHIFT;
                cnt_d   = '0;
                sck_d   = 1'b1;
                bit_d   = '0;
            end
            SHIFT: if (cnt_q == DIV_END) begin
                cnt_d = '0;
                sck_d = ~sck_q;
                // sample on the edge that closes the high half; the sensor moves on our fall
                if (sck_q) begin
                    shift_d = {shift_q[14:0], spi.sio};
                    bit_d   = bit_q + 1'b1;
                end else if (bit_q == 5'd16) begin
                    state_d = HOLD;
                    sck_d   = 1'b0;
                end
            end
            HOLD: if (cnt_q == DIV_END) begin
                state_d = DONE;
                cnt_d   = '0;
            end
            DONE: begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: if (cnt_q == GAP_END) begin
                state_d = ena ? SETUP : IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == DONE) begin
            raw_d = shift_q;
            err_d = !good;
`ifdef LM07_AVG_EN
            if (good) begin
                temp_d = have_q ? 11'(sum >>> 1) : shift_q[15:5];
                hist_d = shift_q[15:5];
                have_d = 1'b1;
            end
`else
            if (good) temp_d = shift_q[15:5];
`endif
        end
        cs_d    = !(state_d inside {SETUP, SHIFT, HOLD});
        valid_d = state_d == DONE;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            raw_q   <= '0;
            temp_q  <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef LM07_AVG_EN
            hist_q  <= '0;
            have_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            raw_q   <= raw_d;
            temp_q  <= temp_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef LM07_AVG_EN
            hist_q  <= hist_d;
            have_q  <= have_d;
`endif
        end

    assign spi.cs    = cs_q;
    assign spi.sck   = sck_q;
    assign temp_raw  = raw_q;
    assign temp_int  = temp_q[10:2];
    assign temp_frac = temp_q[1:0];
    assign valid     = valid_q;
    assign frame_err = err_q;
    assign busy      = busy_q;
endmodule
